// File: rtl/imm_ext_pkg.sv
// Shared types and field constants for the immediate-extension pipeline.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_ROT8   = 2'b00,
        IMM_ZEXT12 = 2'b01,
        IMM_BR24   = 2'b10,
        IMM_SEXT24 = 2'b11
    } imm_mode_t;

    localparam int ROT_FIELD_LSB = 8;
    localparam int IMM8_W        = 8;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: rotated imm8, zero-extended imm12,
// branch offset (sign-extended, x4) and plain sign extension.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  data_i,
    input  imm_mode_t        mode_i,
    output logic [OUT_W-1:0] data_o,
    output logic             carry_o,
    output logic             carry_vld_o
);

    logic [4:0]       rot;
    int unsigned      rot_mod;
    logic [OUT_W-1:0] imm8_zext;
    logic [OUT_W-1:0] rot_val;
    logic [OUT_W-1:0] sext;

    // The rotate field encodes half the rotate amount.
    assign rot       = {data_i[ROT_FIELD_LSB +: 4], 1'b0};
    assign imm8_zext = {{(OUT_W-IMM8_W){1'b0}}, data_i[IMM8_W-1:0]};
    assign sext      = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};

    always_comb begin
        rot_mod = 32'(rot) % 32'(OUT_W);
        rot_val = (imm8_zext >> rot_mod)
                | (imm8_zext << ((32'(OUT_W) - rot_mod) % 32'(OUT_W)));
    end

    always_comb begin
        data_o      = '0;
        carry_o     = 1'b0;
        carry_vld_o = 1'b0;
        case (mode_i)
            IMM_ROT8: begin
                data_o      = rot_val;
                carry_vld_o = (rot != 5'd0);
                carry_o     = (rot != 5'd0) && rot_val[OUT_W-1];
            end
            IMM_ZEXT12: data_o = {{(OUT_W-12){1'b0}}, data_i[11:0]};
            IMM_BR24:   data_o = {sext[OUT_W-3:0], 2'b00};
            IMM_SEXT24: data_o = sext;
            default:    data_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage elastic immediate-extension pipeline: stage 1 captures the raw
// field, stage 2 registers the extended operand into the output registers.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_carry,
    output logic             out_carry_vld
);

    logic             s1_valid_q;
    logic [IN_W-1:0]  s1_data_q;
    imm_mode_t        s1_mode_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_carry_q;
    logic             out_carry_vld_q;
    logic [OUT_W-1:0] out_data_d;
    logic             out_carry_d;
    logic             out_carry_vld_d;
    logic             s1_adv;
    logic             s2_adv;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: capture raw field and mode
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_data_q <= in_data;
            s1_mode_q <= imm_mode_t'(in_mode);
        end
    end

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .data_i      (s1_data_q),
        .mode_i      (s1_mode_q),
        .data_o      (out_data_d),
        .carry_o     (out_carry_d),
        .carry_vld_o (out_carry_vld_d)
    );

    // Stage 2: register extended result; outputs hold while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_carry_q     <= 1'b0;
            out_carry_vld_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q      <= out_data_d;
                    out_carry_q     <= out_carry_d;
                    out_carry_vld_q <= out_carry_vld_d;
                end
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_carry     = out_carry_q;
    assign out_carry_vld = out_carry_vld_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed cases, backpressure,
// randomised handshakes against a reference model, and mid-stream reset.
module tb_imm_extend_pipe;

    localparam int IN_W  = 24;
    localparam int OUT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_carry;
    logic             out_carry_vld;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_mode       (in_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_carry     (out_carry),
        .out_carry_vld (out_carry_vld)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {carry_vld, carry, data}
    function automatic logic [33:0] model(input logic [23:0] d, input logic [1:0] m);
        longint unsigned mask = 64'hFFFF_FFFF;
        longint unsigned v;
        longint          s;
        int              r;
        logic [31:0]     res;
        logic            cv;
        cv = 1'b0;
        s  = longint'(d);
        if (d[23]) s = s - (longint'(1) << 24);
        case (m)
            2'd0: begin
                v   = longint'(d[7:0]);
                r   = 2 * int'(d[11:8]);
                res = (r == 0) ? 32'(v) : 32'(((v >> r) | (v << (32 - r))) & mask);
                cv  = (r != 0);
            end
            2'd1:    res = 32'(d[11:0]);
            2'd2:    res = 32'((s * 4) & longint'(mask));
            default: res = 32'(s & longint'(mask));
        endcase
        return {cv, cv & res[31], res};
    endfunction

    task automatic run_single(input string tag, input logic [23:0] d, input logic [1:0] m,
                              input logic [31:0] ed, input logic ec, input logic ecv);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        #1;
        chk({tag, ".empty"}, out_valid, 0);
        chk({tag, ".rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, ".lat1"}, out_valid, 0);
        @(negedge clk);
        #1;
        chk({tag, ".lat2"}, out_valid, 1);
        chk({tag, ".data"}, out_data, ed);
        chk({tag, ".carry"}, {out_carry, out_carry_vld}, {ec, ecv});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0]  got[$];
        logic [33:0]  exp_q[$];
        logic [33:0]  held_val;
        logic         held;
        logic         c_acc;
        int           sent;
        int           rcvd;
        int           cyc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.valid", out_valid, 0);
        chk("rst.data", out_data, 0);
        chk("rst.carry", {out_carry, out_carry_vld}, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst.rdy", in_ready, 1);

        run_single("sext.pos", 24'd543,     2'd3, 32'h0000021F, 1'b0, 1'b0);
        run_single("sext.neg", 24'hFFFDE1,  2'd3, 32'hFFFFFDE1, 1'b0, 1'b0);
        run_single("sext.m1",  24'hFFFFFF,  2'd3, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_single("rot.4ff",  24'h0004FF,  2'd0, 32'hFF000000, 1'b1, 1'b1);
        run_single("rot.0ab",  24'h0000AB,  2'd0, 32'h000000AB, 1'b0, 1'b0);
        run_single("rot.f01",  24'h000F01,  2'd0, 32'h00000004, 1'b0, 1'b1);
        run_single("zext",     24'h0F3ABC,  2'd1, 32'h00000ABC, 1'b0, 1'b0);
        run_single("br.neg",   24'hFFFFFE,  2'd2, 32'hFFFFFFF8, 1'b0, 1'b0);
        run_single("br.pos",   24'h000010,  2'd2, 32'h00000040, 1'b0, 1'b0);

        // Backpressure: A and B fit, C must stall
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd3;
        in_data   = 24'h000123;
        #1;
        chk("bp.a.rdy", in_ready, 1);
        @(negedge clk);
        in_data = 24'h800000;
        #1;
        chk("bp.b.rdy", in_ready, 1);
        @(negedge clk);
        in_data = 24'h7FFFFF;
        #1;
        chk("bp.c.rdy", in_ready, 0);
        chk("bp.valid", out_valid, 1);
        chk("bp.a.out", out_data, 32'h00000123);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("bp.hold.rdy", in_ready, 0);
            chk("bp.hold.data", out_data, 32'h00000123);
        end
        c_acc = 1'b0;
        for (int i = 0; i < 20 && got.size() < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = !c_acc;
            #1;
            if (in_valid && in_ready) c_acc = 1'b1;
            if (out_valid) got.push_back(out_data);
        end
        in_valid = 1'b0;
        chk("bp.c.acc", c_acc, 1);
        chk("bp.count", got.size(), 3);
        if (got.size() > 0) chk("bp.o0", got[0], 32'h00000123);
        if (got.size() > 1) chk("bp.o1", got[1], 32'hFF800000);
        if (got.size() > 2) chk("bp.o2", got[2], 32'h007FFFFF);
        @(negedge clk);
        #1;
        chk("bp.drained", out_valid, 0);

        // Randomised handshakes against the model
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        held = 1'b0;
        held_val = '0;
        while ((sent < 1000 || exp_q.size() > 0) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = 24'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            #1;
            if (held)
                chk("rnd.stable", {out_valid, out_carry_vld, out_carry, out_data}, {1'b1, held_val});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("rnd.extra", 1, 0);
                else chk("rnd.data", {out_carry_vld, out_carry, out_data}, exp_q.pop_front());
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, in_mode));
                sent++;
            end
            held     = out_valid && !out_ready;
            held_val = {out_carry_vld, out_carry, out_data};
        end
        in_valid = 1'b0;
        chk("rnd.count", rcvd, 1000);
        chk("rnd.timeout", (cyc < 30000), 1);

        // Reset with two items in flight
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd3;
        in_data   = 24'h000005;
        #1;
        chk("mid.a.rdy", in_ready, 1);
        @(negedge clk);
        in_data = 24'h000006;
        #1;
        chk("mid.b.rdy", in_ready, 1);
        @(negedge clk);
        reset   = 1'b1;
        in_data = 24'h000077;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid.valid", out_valid, 0);
        chk("mid.data", out_data, 0);
        chk("mid.carry", {out_carry, out_carry_vld}, 0);
        chk("mid.rdy", in_ready, 1);
        run_single("mid.post", 24'h000042, 2'd3, 32'h00000042, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("mid.drained", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the ARM calculator datapath. It generalises the fixed 24→32 sign/zero extender with four ARM immediate modes:
- data-processing rotated imm8
- zero-extended imm12
- branch imm24 sign-extended and shifted left by 2
- plain imm24 sign-extend

It is a 2-stage elastic pipeline with valid/ready handshakes on both sides, sitting between decode and the register-read/ALU operand mux.

Parameters:
IN_W, 24, width of the raw immediate field from the instruction; must be ≥ 12.
OUT_W, 32, width of the extended operand; must be ≥ IN_W+2 and even.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  upstream presents a valid immediate.
in_ready  output  1  block can accept an input this cycle.
in_data  input  IN_W  raw instruction immediate field, bits [IN_W-1:0].
in_mode  input  2  IMM_ROT8=00, IMM_ZEXT12=01, IMM_BR24=10, IMM_SEXT24=11.
out_valid  output  1  out_data/out_carry hold a valid result.
out_ready  input  1  downstream accepts the result this cycle.
out_data  output  OUT_W  extended immediate.
out_carry  output  1  shifter carry-out for IMM_ROT8; 0 for other modes.
out_carry_vld  output  1  1 only when mode IMM_ROT8 and rotate amount ≠ 0, meaning the ALU must update C.

Behaviour:
- Handshake: transfer occurs when valid and ready are both high on a rising edge.
  - in_valid/in_data/in_mode need not stay stable without in_ready.
  - out_valid, once high, holds with stable out_data/out_carry/out_carry_vld until out_ready.
- Pipeline:
  - Stage 1 registers in_data and in_mode (s1_valid).
  - Stage 2 computes the extension from the stage-1 registers and registers the result into the output registers (s2_valid = out_valid).
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv; a combinational out_ready→in_ready path is permitted.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 per cycle.
- Full condition: s1_valid && out_valid && !out_ready → in_ready=0. No data is dropped or reordered; capacity is exactly 2 items.
- Arithmetic, with imm = stage-1 data:
  - IMM_ROT8: imm8=imm[7:0], rot=2*imm[11:8]. out_data = zero-extended imm8 rotated right by rot mod OUT_W. out_carry = out_data[OUT_W-1] when rot≠0, else 0. out_carry_vld = (rot≠0).
  - IMM_ZEXT12: out_data = imm[11:0] zero-extended; bits above 11 are ignored.
  - IMM_BR24: out_data = sign-extend(imm[IN_W-1:0]) << 2, truncated to OUT_W.
  - IMM_SEXT24: out_data = sign-extend(imm[IN_W-1:0]), i.e. legacy ExtImm=1 behaviour.
- Reset:
  - s1_valid=0, out_valid=0, out_data=0, out_carry=0, out_carry_vld=0.
  - in_ready reads 1 the cycle after reset deasserts.
  - Reset mid-stream discards all in-flight items. in_valid during reset is not captured.
- Simultaneous events: stage-2 drain, stage-1→stage-2 move and new input capture all occur in the same edge when out_ready=1.

Decomposition:
- Package imm_ext_pkg holds:
  - the imm_mode_t 2-bit enum (IMM_ROT8, IMM_ZEXT12, IMM_BR24, IMM_SEXT24)
  - the ROT_FIELD_LSB=8 and IMM8_W=8 constants
- One combinational sub-module imm_ext_core computes out_data/out_carry/out_carry_vld from (data, mode). The top holds only pipeline registers and handshake logic.

Test Plan:
- Legacy SEXT24 with out_ready=1: in_data=24'd543, 24'hFFFDE1 (−543), 24'hFFFFFF (−1) → out_data 32'h0000021F, 32'hFFFFFDE1, 32'hFFFFFFFF, each exactly 2 cycles after accept. out_carry_vld=0.
- ROT8: in_data=12'h4FF → out_data=32'hFF000000, out_carry=1, out_carry_vld=1. in_data=12'h0AB → 32'h000000AB, out_carry_vld=0.
- ZEXT12 and BR24:
  - ZEXT12 in_data=24'hF3ABC → 32'h00000ABC.
  - BR24 in_data=24'hFFFFFE → 32'hFFFFFFF8.
  - BR24 in_data=24'h000010 → 32'h00000040.
- Backpressure:
  - Hold out_ready=0 and offer 3 back-to-back items A,B,C.
  - Required: A and B accepted, in_ready=0 on the third cycle, C held; out_data=A is stable.
  - Release out_ready: outputs A,B,C in order, none lost or duplicated.
- Randomised valid/ready toggling for 1000 items against a reference model of all 4 modes → exact in-order match.
- Assert reset for 1 cycle with 2 items in flight → next cycle out_valid=0, out_data=0, in_ready=1; the first post-reset item emerges 2 cycles after accept.
